// File: rtl/shared_pkg.sv
// Shared defaults for the parametrised synchronous FIFO and the bench-wide completion flag.
// Build option: FIFO_FWFT_EN selects first-word-fall-through output in fifo_sync_param.
package shared_pkg;

    localparam int unsigned FIFO_WIDTH_DEF = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned AF_LEVEL_DEF   = FIFO_DEPTH_DEF - 1;
    localparam int unsigned AE_LEVEL_DEF   = 1;

    bit test_finished;

endpackage

// File: rtl/fifo_sync_ptr.sv
// Wrapping FIFO pointer: counts 0..DEPTH-1 and returns to 0, so any depth works.
module fifo_sync_ptr #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (inc) begin
            if (r_ptr == PW'(DEPTH - 1)) begin
                r_ptr <= '0;
            end else begin
                r_ptr <= r_ptr + PW'(1);
            end
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with arbitrary depth, programmable almost-flags and registered status pulses.
// Build option: define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module fifo_sync_param
    import shared_pkg::*;
#(
    parameter int unsigned FIFO_WIDTH = FIFO_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int unsigned AE_LEVEL   = AE_LEVEL_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              wr_en,
    input  logic                              rd_en,
    input  logic [FIFO_WIDTH-1:0]             data_in,
    output logic [FIFO_WIDTH-1:0]             data_out,
    output logic                              wr_ack,
    output logic                              overflow,
    output logic                              underflow,
    output logic                              full,
    output logic                              empty,
    output logic                              almostfull,
    output logic                              almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("fifo_sync_param: FIFO_DEPTH must be at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH - 1) begin : g_bad_af
        $error("fifo_sync_param: AF_LEVEL must lie in 1..FIFO_DEPTH-1");
    end
    if (AE_LEVEL < 1 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
        $error("fifo_sync_param: AE_LEVEL must lie in 1..FIFO_DEPTH-1");
    end

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         w_wr_ptr;
    logic [PW-1:0]         w_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = rd_en && !w_empty;
    // A full FIFO still takes a write when a read frees the slot on the same edge.
    assign w_wr_acc = wr_en && (!w_full || w_rd_acc);

    fifo_sync_ptr #(
        .DEPTH (FIFO_DEPTH),
        .PW    (PW)
    ) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_wr_acc),
        .ptr (w_wr_ptr)
    );

    fifo_sync_ptr #(
        .DEPTH (FIFO_DEPTH),
        .PW    (PW)
    ) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (w_rd_acc),
        .ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[w_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - CW'(1);
            end
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= wr_en && !w_wr_acc;
            r_underflow <= rd_en && !w_rd_acc;
        end
    end

`ifdef FIFO_FWFT_EN
    assign data_out = w_empty ? '0 : r_mem[w_rd_ptr];
`else
    logic [FIFO_WIDTH-1:0] r_data_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_acc) begin
            r_data_out <= r_mem[w_rd_ptr];
        end
    end

    assign data_out = r_data_out;
`endif

    assign wr_ack      = r_wr_ack;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almostfull  = (r_count >= CW'(AF_LEVEL)) && !w_full;
    assign almostempty = !w_empty && (r_count <= CW'(AE_LEVEL));
    assign count       = r_count;

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised single-clock synchronous FIFO, the next generation of the team's verified FIFO. It generalises data width and depth, including non-power-of-two depths. It adds programmable almost-full/almost-empty thresholds, a live occupancy count and registered status pulses. It sits between any producer/consumer pair in the same clock domain, and its status outputs feed the scoreboard and coverage in the existing UVM-lite bench.

## Interface
- FIFO_WIDTH, 16, data bits per entry (≥1)
- FIFO_DEPTH, 8, number of entries (≥2, any integer)
- AF_LEVEL, FIFO_DEPTH-1, count at or above which almostfull asserts (1..FIFO_DEPTH-1)
- AE_LEVEL, 1, count at or below which almostempty asserts while not empty (1..FIFO_DEPTH-1)
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- rd_en  in  1  read request
- data_in  in  FIFO_WIDTH  write data
- data_out  out  FIFO_WIDTH  read data
- wr_ack  out  1  registered pulse: the previous cycle's write was accepted
- overflow  out  1  registered pulse: the previous cycle's write was rejected because the FIFO was full
- underflow  out  1  registered pulse: the previous cycle's read was rejected because the FIFO was empty
- full  out  1  count == FIFO_DEPTH (combinational from count)
- empty  out  1  count == 0
- almostfull  out  1  AF_LEVEL ≤ count < FIFO_DEPTH
- almostempty  out  1  0 < count ≤ AE_LEVEL
- count  out  $clog2(FIFO_DEPTH+1)  current occupancy

## Operation
- Write accepted when wr_en && (!full || rd accepted same cycle). Read accepted when rd_en && !empty.
- Full + wr_en + rd_en: read and write both accepted; count unchanged; no overflow.
- Empty + wr_en + rd_en: write accepted; read rejected with underflow; count +1.
- Rejected write: memory and pointers unchanged; overflow pulses the next cycle.
- Rejected read: data_out holds its value; underflow pulses the next cycle.
- wr_ptr and rd_ptr each run 0..FIFO_DEPTH-1 and wrap to 0 after FIFO_DEPTH-1 (explicit compare, no power-of-two masking).
- count: +1 on write only, -1 on read only, unchanged on both or neither. count never exceeds FIFO_DEPTH and never goes below 0.
- Reset: pointers 0, count 0, data_out 0, and wr_ack/overflow/underflow 0. Hence empty=1 and full, almostfull and almostempty are 0. Memory contents are not reset.
- Reset has priority over any simultaneous wr_en/rd_en. Mid-operation reset discards all contents in one cycle.

## Timing
- Standard mode: an accepted read at edge N updates data_out at edge N (visible in cycle N+1). Read latency is 1 cycle.
- wr_ack, overflow and underflow assert for exactly one cycle following the request cycle. They repeat every cycle while the condition persists.
- Flags and count reflect state after the last edge. A write is readable the cycle after it is accepted.

## Configuration
- FIFO_FWFT_EN defined: first-word-fall-through. data_out combinationally shows mem[rd_ptr] whenever !empty, and 0 when empty. rd_en pops the current word and has zero read latency. All flag and handshake rules are unchanged.
- FIFO_FWFT_EN undefined: standard registered-output mode as above.

## Structure
- shared_pkg holds the default constants FIFO_WIDTH_DEF, FIFO_DEPTH_DEF, AF_LEVEL_DEF and AE_LEVEL_DEF, plus the bench-wide test_finished flag.
- One sub-module, fifo_sync_ptr: a parametrised wrapping pointer (inc, rst → ptr) instantiated for wr_ptr and rd_ptr.
- Elaboration check rejects FIFO_DEPTH < 2 or thresholds outside 1..FIFO_DEPTH-1.

## Test plan
- Reset with wr_en=rd_en=1 → count=0, empty=1, wr_ack=overflow=underflow=0 on the cycle after.
- DEPTH=8: 8 writes of 0..7 → full=1 and count=8; 9th write → overflow=1 for one cycle, count stays 8; 8 reads → data_out 0..7 in order, empty=1.
- Full + wr_en + rd_en with data_in=0xAA → wr_ack=1, overflow=0, count=8, and 0xAA is read out last.
- Empty + rd_en only → underflow=1 next cycle, data_out unchanged. Empty + wr_en + rd_en → wr_ack=1, underflow=1, count=1.
- DEPTH=6, AF_LEVEL=5, AE_LEVEL=2: 20 random-mix operations crossing the wrap → pointers wrap 5→0, data order preserved, almostfull only at count 5, almostempty only at count 1..2.
- FIFO_FWFT_EN: write 0x1234 into empty → data_out=0x1234 the next cycle with no rd_en; rd_en pops it → empty=1, data_out=0.
